// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit side: arbiter FSM states
// and frame-length arithmetic.
package uart_pkg;

  localparam int UART_BITS_OVERHEAD = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } arb_state_t;

  // Clock cycles one frame occupies on the line: start + data + stop bits, plus any guard time.
  function automatic int frame_cycles(input int baud_divisor, input int frame_size, input int guard);
    return baud_divisor * (frame_size + UART_BITS_OVERHEAD) + guard;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or above
// ptr, wrapping around, and reports it as one-hot grant plus index.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]                          req,
  input  logic [$clog2(NUM_REQ > 1 ? NUM_REQ : 2)-1:0] ptr,
  input  logic                                        enable,
  output logic [NUM_REQ-1:0]                          grant,
  output logic [$clog2(NUM_REQ > 1 ? NUM_REQ : 2)-1:0] grant_idx
);

  localparam int IW = $clog2(NUM_REQ > 1 ? NUM_REQ : 2);

  int idx;

  // Scan from farthest to nearest so the candidate closest to ptr is the last to be written.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    if (enable) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          grant_idx  = IW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx_control among NUM_REQ byte producers, one byte per grant.
// Optional grant locking for multi-byte messages is enabled with `define UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_SIZE   = 8,
  parameter int BAUD_DIVISOR = 10417,
  parameter int GUARD_CYCLES = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req_valid,
  input  logic [NUM_REQ*FRAME_SIZE-1:0]               req_data,
  input  logic [NUM_REQ-1:0]                          req_lock,
  output logic [NUM_REQ-1:0]                          req_ready,
  output logic [FRAME_SIZE-1:0]                       tx_data,
  output logic                                        tx_start,
  output logic                                        busy,
  output logic [$clog2(NUM_REQ > 1 ? NUM_REQ : 2)-1:0] grant_id
);

  localparam int IW           = $clog2(NUM_REQ > 1 ? NUM_REQ : 2);
  localparam int FRAME_CYCLES = frame_cycles(BAUD_DIVISOR, FRAME_SIZE, GUARD_CYCLES);
  localparam int CW           = $clog2(FRAME_CYCLES + 1);

  arb_state_t          state, state_next;
  logic [CW-1:0]       counter;
  logic [IW-1:0]       rr_ptr, win_idx, ptr_next;
  logic [NUM_REQ-1:0]  arb_req, win_onehot;
  logic                arb_en, accept, frame_done;

  assign frame_done = (state == WAIT) && (counter == '0);

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_q;
  logic lock_hold;

  // While the previous owner keeps its lock raised, only it may win.
  assign lock_hold = lock_q && req_lock[grant_id];

  always_comb begin
    arb_req = req_valid;
    if (lock_hold) arb_req = req_valid & (NUM_REQ'(1) << grant_id);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        lock_q <= 1'b0;
    else if (frame_done)                            lock_q <= req_lock[grant_id];
    else if (state == IDLE && !req_lock[grant_id])  lock_q <= 1'b0;
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign arb_req     = req_valid;
`endif

  assign arb_en = (state == IDLE) && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .enable    (arb_en),
    .grant     (win_onehot),
    .grant_idx (win_idx)
  );

  assign req_ready = win_onehot;
  assign accept    = |win_onehot;
  assign ptr_next  = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IW'(1);

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE:  if (accept) state_next = START;
      START: begin
        tx_start   = 1'b1;
        busy       = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (frame_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The transmitter has no done output, so the frame is timed here from the tx_start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      counter  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        tx_data  <= req_data[win_idx*FRAME_SIZE +: FRAME_SIZE];
        grant_id <= win_idx;
        rr_ptr   <= ptr_next;
      end
      if (state == START)                       counter <= CW'(FRAME_CYCLES - 1);
      else if (state == WAIT && counter != '0)  counter <= counter - CW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, BAUD_DIVISOR=4, FRAME_CYCLES=40).
// Build with +define+UART_TX_ARB_LOCK_EN to also exercise grant locking.
module tb_uart_tx_arbiter;

  typedef struct {
    logic [3:0] onehot;
    int         cyc;
  } rdy_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    int         cyc;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic [1:0]  grant_id;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  rdy_t rdy_q[$];
  tx_t  tx_q[$];
  rdy_t rdy_item;
  tx_t  tx_item;

  uart_tx_arbiter #(
    .NUM_REQ(4), .FRAME_SIZE(8), .BAUD_DIVISOR(4), .GUARD_CYCLES(0)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data, input logic [3:0] lock);
    req_valid = valid;
    req_data  = data;
    req_lock  = lock;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic expectGrant(input logic [3:0] onehot, input logic [7:0] data, input logic [1:0] id, input int at);
    rdy_q.push_back('{onehot: onehot, cyc: at});
    tx_q.push_back('{data: data, id: id, cyc: at + 1});
  endtask

  // Monitor: every acceptance and every start pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (req_ready !== 4'b0000) begin
      if (rdy_q.size() == 0) checkOutput("unexpected_ready", 32'(req_ready), 32'h0);
      else begin
        rdy_item = rdy_q.pop_front();
        checkOutput("ready_onehot", 32'(req_ready), 32'(rdy_item.onehot));
        checkOutput("ready_cycle", cyc, rdy_item.cyc);
      end
    end
    if (tx_start !== 1'b0) begin
      if (tx_q.size() == 0) checkOutput("unexpected_tx_start", 32'(tx_start), 32'h0);
      else begin
        tx_item = tx_q.pop_front();
        checkOutput("tx_data", 32'(tx_data), 32'(tx_item.data));
        checkOutput("grant_id", 32'(grant_id), 32'(tx_item.id));
        checkOutput("tx_start_cycle", cyc, tx_item.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int c;
    rst = 1'b1;
    applyStimulus(4'h0, 32'h0, 4'h0);
    tick();
    applyStimulus(4'hF, 32'hA3A2A1A0, 4'h0);
    tick();
    checkOutput("reset_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_tx_start", 32'(tx_start), 32'h0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'h0);
    checkOutput("reset_grant_id", 32'(grant_id), 32'h0);

    // All four requesters held valid: grants 0,1,2,3,0 spaced 42 cycles.
    tick();
    rst = 1'b0;
    c = cyc;
    expectGrant(4'b0001, 8'hA0, 2'd0, c);
    expectGrant(4'b0010, 8'hA1, 2'd1, c + 42);
    expectGrant(4'b0100, 8'hA2, 2'd2, c + 84);
    expectGrant(4'b1000, 8'hA3, 2'd3, c + 126);
    expectGrant(4'b0001, 8'hA0, 2'd0, c + 168);
    tickTo(c + 169);
    applyStimulus(4'h0, 32'hA3A2A1A0, 4'h0);
    waitIdle();

    // Single request from requester 0; busy window and frozen tx_data.
    c = cyc;
    applyStimulus(4'b0001, 32'h00000055, 4'h0);
    expectGrant(4'b0001, 8'h55, 2'd0, c);
    tickTo(c + 2);
    applyStimulus(4'b0000, 32'h00000055, 4'h0);
    checkOutput("tx_start_one_cycle", 32'(tx_start), 32'h0);
    tickTo(c + 5);
    applyStimulus(4'b0000, 32'h000000EE, 4'h0);
    tickTo(c + 41);
    checkOutput("busy_last_wait", 32'(busy), 32'h1);
    checkOutput("tx_data_frozen", 32'(tx_data), 32'h55);
    tickTo(c + 42);
    checkOutput("busy_back_idle", 32'(busy), 32'h0);

    // Requester 2 arrives mid-frame; requester 0 pulses valid and withdraws.
    c = cyc;
    applyStimulus(4'b0010, 32'h00001100, 4'h0);
    expectGrant(4'b0010, 8'h11, 2'd1, c);
    expectGrant(4'b0100, 8'h22, 2'd2, c + 42);
    tickTo(c + 1);
    applyStimulus(4'b0000, 32'h00001100, 4'h0);
    tickTo(c + 5);
    applyStimulus(4'b0100, 32'h00220000, 4'h0);
    tickTo(c + 10);
    applyStimulus(4'b0101, 32'h00220033, 4'h0);
    tickTo(c + 15);
    applyStimulus(4'b0100, 32'h00220033, 4'h0);
    tickTo(c + 41);
    checkOutput("no_ready_in_wait", 32'(req_ready), 32'h0);
    tickTo(c + 43);
    applyStimulus(4'b0000, 32'h0, 4'h0);
    waitIdle();

    // Reset 20 cycles into WAIT, then arbitration restarts from pointer 0.
    c = cyc;
    applyStimulus(4'b0010, 32'h00007700, 4'h0);
    expectGrant(4'b0010, 8'h77, 2'd1, c);
    tickTo(c + 1);
    applyStimulus(4'b0000, 32'h00007700, 4'h0);
    tickTo(c + 22);
    rst = 1'b1;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'h0);
    checkOutput("midreset_tx_start", 32'(tx_start), 32'h0);
    checkOutput("midreset_tx_data", 32'(tx_data), 32'h0);
    checkOutput("midreset_grant_id", 32'(grant_id), 32'h0);
    tick();
    rst = 1'b0;
    c = cyc;
    applyStimulus(4'b1010, 32'hC3005A00, 4'h0);
    expectGrant(4'b0010, 8'h5A, 2'd1, c);
    expectGrant(4'b1000, 8'hC3, 2'd3, c + 42);
    tickTo(c + 1);
    applyStimulus(4'b1000, 32'hC3005A00, 4'h0);
    tickTo(c + 43);
    applyStimulus(4'b0000, 32'h0, 4'h0);
    waitIdle();

`ifdef UART_TX_ARB_LOCK_EN
    // Requester 1 holds the lock for three bytes while requester 3 waits.
    c = cyc;
    applyStimulus(4'b1010, 32'hD300B000, 4'b0010);
    expectGrant(4'b0010, 8'hB0, 2'd1, c);
    expectGrant(4'b0010, 8'hB1, 2'd1, c + 42);
    expectGrant(4'b0010, 8'hB2, 2'd1, c + 84);
    expectGrant(4'b1000, 8'hD3, 2'd3, c + 126);
    tickTo(c + 1);
    applyStimulus(4'b1010, 32'hD300B100, 4'b0010);
    tickTo(c + 43);
    applyStimulus(4'b1010, 32'hD300B200, 4'b0010);
    tickTo(c + 85);
    applyStimulus(4'b1000, 32'hD300B200, 4'b0000);
    tickTo(c + 127);
    applyStimulus(4'b0000, 32'h0, 4'h0);
    waitIdle();
`endif

    repeat (5) tick();
    checkOutput("ready_queue_drained", rdy_q.size(), 32'h0);
    checkOutput("tx_queue_drained", tx_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
